// File: rtl/hazard_controller_pkg.sv
// Shared types and constants for the RV32I hazard controller.
package hazard_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-to-hazard-controller signal bundle; pipeline is master, controller is slave.
interface hazard_controller_if #(parameter int STALL_CNT_W = 32);
  logic [4:0]             Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic                   ResultSrcE0, PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW;
  logic                   StallF, StallD, StallE, StallM;
  logic                   FlushD, FlushE, FlushW;
  logic [1:0]             ForwardAE, ForwardBE;
  logic                   MemFault;
  logic [STALL_CNT_W-1:0] StallCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
           ResultSrcE0, PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemFault, StallCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
           ResultSrcE0, PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemFault, StallCount
  );
endinterface

// File: rtl/hazard_controller_forward_unit.sv
// EX operand bypass select for one source register; M result beats W result.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);
  always_comb begin
    fwd = FWD_RF;
    if (reg_write_w && rd_w != 5'd0 && rd_w == rs) fwd = FWD_W;
    if (reg_write_m && rd_m != 5'd0 && rd_m == rs) fwd = FWD_M;
  end
endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forward generation with a memory-wait timeout FSM and stall-cycle counter.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int STALL_CNT_W = 32
) (
  input logic              clk,
  input logic              rst,
  hazard_controller_if.slave hif
);
  localparam int WCW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  state_e                 state, state_n;
  logic [WCW-1:0]         wait_cnt, wait_n;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [1:0]             fwd_a, fwd_b;
  logic                   mem_stall, lw_stall;
  logic                   stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;

  forward_unit u_fwd_a (.rs(hif.Rs1E), .rd_m(hif.RdM), .reg_write_m(hif.RegWriteM),
                        .rd_w(hif.RdW), .reg_write_w(hif.RegWriteW), .fwd(fwd_a));
  forward_unit u_fwd_b (.rs(hif.Rs2E), .rd_m(hif.RdM), .reg_write_m(hif.RegWriteM),
                        .rd_w(hif.RdW), .reg_write_w(hif.RegWriteW), .fwd(fwd_b));

  assign mem_stall = hif.MemReqM & ~hif.MemReadyM;
  assign lw_stall  = hif.ResultSrcE0 & (hif.RdE != 5'd0) &
                     ((hif.RdE == hif.Rs1D) | (hif.RdE == hif.Rs2D));

  always_comb begin
    {stall_f, stall_d, stall_e, stall_m} = 4'b0000;
    {flush_d, flush_e, flush_w}          = 3'b000;
    if (rst) begin
      {flush_d, flush_e, flush_w} = 3'b111;
    end else if (state == FAULT || mem_stall) begin
      // Whole pipe frozen; E keeps presenting its branch/load so they resolve later.
      {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
      flush_w = 1'b1;
    end else if (hif.PCSrcE) begin
      {flush_d, flush_e} = 2'b11;
    end else if (lw_stall) begin
      {stall_f, stall_d, flush_e} = 3'b111;
    end
  end

  always_comb begin
    state_n = state;
    wait_n  = wait_cnt;
    case (state)
      RUN: if (mem_stall) begin
        state_n = MEM_WAIT;
        wait_n  = WCW'(1);
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_n = RUN;
          wait_n  = '0;
        end else if (wait_cnt == WCW'(MEM_TIMEOUT - 1)) begin
          state_n = FAULT;
        end else begin
          wait_n = wait_cnt + WCW'(1);
        end
      end
      default: state_n = FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
      if (stall_f && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign hif.StallF     = stall_f;
  assign hif.StallD     = stall_d;
  assign hif.StallE     = stall_e;
  assign hif.StallM     = stall_m;
  assign hif.FlushD     = flush_d;
  assign hif.FlushE     = flush_e;
  assign hif.FlushW     = flush_w;
  assign hif.ForwardAE  = rst ? FWD_RF : fwd_a;
  assign hif.ForwardBE  = rst ? FWD_RF : fwd_b;
  assign hif.MemFault   = (state == FAULT);
  assign hif.StallCount = stall_cnt;
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core. Generates per-stage stall and flush enables, plus EX-stage forwarding selects, from decode/execute/memory/writeback register addresses and control.
- Adds a registered memory-wait FSM with a timeout fault, and a saturating stall-cycle counter for performance monitoring.
- Sits beside the pipeline registers. Drives their enable/clear inputs and the ALU operand muxes in E.

Parameters:
- MEM_TIMEOUT, 16: consecutive data-memory wait cycles before a fault is declared. Legal range ≥2.
- STALL_CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- Rs1D, Rs2D  in  5  source registers of the instruction in D
- Rs1E, Rs2E, RdE  in  5  sources and destination of the instruction in E
- ResultSrcE0  in  1  E-stage instruction is a load
- PCSrcE  in  1  taken branch or jump resolved in E
- RdM  in  5  destination in M
- RegWriteM  in  1  M-stage instruction writes the register file
- MemReqM  in  1  load/store active in M
- MemReadyM  in  1  data memory completes the access this cycle
- RdW  in  5  destination in W
- RegWriteW  in  1  W-stage instruction writes the register file
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE, FlushW  out  1  clear the corresponding pipeline register (bubble)
- ForwardAE, ForwardBE  out  2  operand select: 00 = register file, 01 = W result, 10 = M ALU result
- MemFault  out  1  sticky memory timeout fault
- StallCount  out  STALL_CNT_W  cycles in which StallF was asserted

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- Reset (rst=1):
  - State = RUN; WaitCnt = 0; StallCount = 0; MemFault = 0.
  - FlushD = FlushE = FlushW = 1; all stalls = 0; ForwardAE = ForwardBE = 00.
- Forwarding (combinational, every cycle outside reset):
  - ForwardAE = 10 if RegWriteM and RdM≠0 and RdM==Rs1E.
  - Otherwise 01 if RegWriteW and RdW≠0 and RdW==Rs1E.
  - Otherwise 00. M has priority over W.
  - ForwardBE uses the same rule with Rs2E.
- memStall = MemReqM & ~MemReadyM.
- lwStall = ResultSrcE0 & RdE≠0 & (RdE==Rs1D | RdE==Rs2D).
- Priority, highest first:
  1. FAULT state or memStall:
     - StallF = StallD = StallE = StallM = 1; FlushW = 1; FlushD = FlushE = 0.
     - lwStall and PCSrcE are ignored this cycle (E is frozen, so they re-present).
  2. PCSrcE:
     - FlushD = FlushE = 1; StallF = StallD = 0, even if lwStall, because the D instruction is killed.
  3. lwStall:
     - StallF = StallD = 1; FlushE = 1.
  4. Otherwise: all stalls and flushes 0.
- FSM states: RUN, MEM_WAIT, FAULT.
  - RUN: on memStall go to MEM_WAIT with WaitCnt = 1; otherwise stay.
  - MEM_WAIT:
    - MemReadyM=1 or MemReqM=0 (request withdrawn): go to RUN, WaitCnt = 0.
    - Else if WaitCnt == MEM_TIMEOUT-1: go to FAULT.
    - Else WaitCnt += 1.
  - FAULT: MemFault = 1; all stalls asserted; FlushW = 1. Left only via rst.
  - Result: FAULT is entered after MEM_TIMEOUT consecutive memStall cycles and is visible on the following cycle.
- A single-cycle access (MemReadyM=1 in the first M cycle) never leaves RUN.
- StallCount: +1 on every non-reset cycle with StallF=1; saturates at all-ones and does not wrap.
- Reset mid-MEM_WAIT or in FAULT returns to RUN on the next edge with all counters cleared.
- Latency: stall, flush and forward outputs are combinational (same cycle). MemFault and StallCount are registered.

Decomposition:
- Package hazard_pkg:
  - state enum {RUN, MEM_WAIT, FAULT};
  - forward-select constants FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
- One natural sub-module: forward_unit (pure combinational, instantiated once per operand).
- FSM, priority logic and counters stay in hazard_controller.

Test Plan:
- Forwarding: RegWriteM=1, RdM=5, Rs1E=5, and simultaneously RegWriteW=1, RdW=5 → ForwardAE=10. Same with RdM=0 → ForwardAE=01. Rs2E=7, RdW=7, RegWriteW=1 → ForwardBE=01.
- Load-use: ResultSrcE0=1, RdE=3, Rs2D=3 → StallF=StallD=FlushE=1 for exactly that cycle, StallCount +1. RdE=0 → no stall.
- Branch versus load-use: PCSrcE=1 with lwStall true → FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 → StallF..StallM=1 and FlushW=1 for 3 cycles; state RUN→MEM_WAIT→RUN; StallCount +3; MemFault=0.
- Timeout: MEM_TIMEOUT=4, MemReqM=1, MemReadyM=0 held → MemFault=1 on cycle 5 and stays high after MemReadyM rises. rst pulse → MemFault=0, StallCount=0, state RUN.
- Saturation: STALL_CNT_W=3 with 10 stall cycles → StallCount holds at 7.
